// File: rtl/core_mem_pkg.sv
// ============================================================================
// Module      : core_mem_pkg
// Description : Shared types and constants for core_mem_responder. Holds the
//               arbitrated request record, the stall-LFSR seed/taps, and the
//               word returned to the fetch port for out-of-range fetches.
// Macro       : CORE_MEM_RESP_STALL_EN (consumers only; the package is the
//               same in both builds)
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package core_mem_pkg;

  // One request as seen by the array after arbitration.
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_req_t;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Returned on an out-of-range fetch; the core decodes it as illegal.
  localparam logic [31:0] MEM_OOR_INSTR = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/core_mem_lfsr.sv
// ============================================================================
// Module      : core_mem_lfsr
// Description : Free-running 16-bit Fibonacci LFSR used to inject random
//               grant stalls. Only instantiated when CORE_MEM_RESP_STALL_EN
//               is defined.
// Ports       : clk_i   - clock
//               rst_i   - asynchronous active-high reset (loads seed)
//               stall_o - current LFSR bit 0; 1 means "stall this cycle"
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module core_mem_lfsr
  import core_mem_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  output logic stall_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Shift toward the MSB, feedback enters at bit 0.
  assign lfsr_d  = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  assign stall_o = lfsr_q[0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/core_mem_responder.sv
// ============================================================================
// Module      : core_mem_responder
// Description : Single-port word memory serving the fetch and load/store
//               ports of riscv_core (req/gnt/rvalid). Data has priority
//               except when a fetch was left waiting the previous cycle.
//               Read data returns one cycle after grant. Out-of-range data
//               accesses respond with err; out-of-range fetches return
//               MEM_OOR_INSTR. Completed responses are counted per port.
// Macro       : CORE_MEM_RESP_STALL_EN - when defined, an LFSR forces both
//               grants low in cycles where its bit 0 is set.
// Ports       : clk_i, rst_i (async, active-high)
//               instr_req_i/addr_i -> instr_gnt_o, instr_rvalid_o, instr_rdata_o
//               data_req_i/addr_i/we_i/be_i/wdata_i
//                 -> data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
//               instr_cnt_o, data_cnt_o - completed response counters
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module core_mem_responder
  import core_mem_pkg::*;
#(
  parameter int          MEM_WORDS_LOG2 = 14,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic [31:0] instr_cnt_o,
  output logic [31:0] data_cnt_o
);

  localparam int          MEM_DEPTH = 1 << MEM_WORDS_LOG2;
  localparam logic [32:0] MEM_BYTES = 33'd1 << (MEM_WORDS_LOG2 + 2);

  logic [31:0] mem_q [MEM_DEPTH];

  logic                      stall;
  logic                      instr_gnt;
  logic                      data_gnt;
  logic                      starve_q, starve_d;
  mem_req_t                  req;
  logic [31:0]               offset;
  logic                      in_range;
  logic [MEM_WORDS_LOG2-1:0] idx;

  logic        instr_rvalid_q, data_rvalid_q, data_err_q;
  logic [31:0] instr_rdata_q, data_rdata_q;
  logic [31:0] instr_cnt_q, data_cnt_q;

`ifdef CORE_MEM_RESP_STALL_EN
  core_mem_lfsr u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .stall_o (stall)
  );
`else
  assign stall = 1'b0;
`endif

  // Data wins unless the fetch was held off last cycle; grants are forced
  // low during reset and in stall cycles.
  always_comb begin
    instr_gnt = 1'b0;
    data_gnt  = 1'b0;
    if (!rst_i && !stall) begin
      if (instr_req_i && (starve_q || !data_req_i)) begin
        instr_gnt = 1'b1;
      end else if (data_req_i) begin
        data_gnt = 1'b1;
      end
    end
  end

  // Updated in stall cycles too, so a fetch that was stalled keeps its claim.
  assign starve_d = instr_req_i & ~instr_gnt;

  assign instr_gnt_o = instr_gnt;
  assign data_gnt_o  = data_gnt;

  // Only one grant can be active, so one shared address decode serves both.
  always_comb begin
    req       = '0;
    req.addr  = instr_addr_i;
    if (data_gnt) begin
      req.addr  = data_addr_i;
      req.we    = data_we_i;
      req.be    = data_be_i;
      req.wdata = data_wdata_i;
    end
  end

  assign offset   = req.addr - BASE_ADDR;
  assign in_range = {1'b0, offset} < MEM_BYTES;
  assign idx      = offset[MEM_WORDS_LOG2+1:2];

  // Array: not reset, written only on an in-range granted store.
  always_ff @(posedge clk_i) begin
    if (data_gnt && req.we && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (req.be[b]) begin
          mem_q[idx][8*b +: 8] <= req.wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q       <= 1'b0;
      instr_rvalid_q <= 1'b0;
      instr_rdata_q  <= '0;
      data_rvalid_q  <= 1'b0;
      data_rdata_q   <= '0;
      data_err_q     <= 1'b0;
      instr_cnt_q    <= '0;
      data_cnt_q     <= '0;
    end else begin
      starve_q       <= starve_d;
      instr_rvalid_q <= instr_gnt;
      data_rvalid_q  <= data_gnt;
      // Counters advance with the edge that raises rvalid, so the count
      // already includes the response on display.
      instr_cnt_q    <= instr_cnt_q + {31'd0, instr_gnt};
      data_cnt_q     <= data_cnt_q + {31'd0, data_gnt};
      if (instr_gnt) begin
        instr_rdata_q <= in_range ? mem_q[idx] : MEM_OOR_INSTR;
      end
      if (data_gnt) begin
        data_rdata_q <= (in_range && !req.we) ? mem_q[idx] : 32'h0;
        data_err_q   <= ~in_range;
      end
    end
  end

  assign instr_rvalid_o = instr_rvalid_q;
  assign instr_rdata_o  = instr_rdata_q;
  assign data_rvalid_o  = data_rvalid_q;
  assign data_rdata_o   = data_rdata_q;
  assign data_err_o     = data_err_q;
  assign instr_cnt_o    = instr_cnt_q;
  assign data_cnt_o     = data_cnt_q;

endmodule

`default_nettype wire

// File: doc/core_mem_responder.md
# core_mem_responder

Single-port word memory that answers both memory interfaces of `riscv_core`, the instruction fetch port and the load/store port. It uses the core's req/gnt/rvalid protocol. It arbitrates the two requesters onto one array and returns read data one cycle after grant. It flags out-of-range data accesses and counts completed transactions. It is the memory stage that sits directly upstream of the core in simulation and FPGA bring-up.

## Interface
Parameters:
- `MEM_WORDS_LOG2`, default 14: array depth is 2^MEM_WORDS_LOG2 32-bit words (64 KiB).
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0.

Ports:
- `clk_i` input 1: the only clock; all logic on the rising edge.
- `rst_i` input 1: asynchronous, active-high reset.
- `instr_req_i` input 1: fetch request.
- `instr_addr_i` input 32: fetch byte address; bits [1:0] ignored.
- `instr_gnt_o` output 1: fetch accepted this cycle (combinational).
- `instr_rvalid_o` output 1: fetch response valid.
- `instr_rdata_o` output 32: fetch data.
- `data_req_i` input 1: load/store request.
- `data_addr_i` input 32: byte address; bits [1:0] ignored.
- `data_we_i` input 1: 1 = store.
- `data_be_i` input 4: byte enables for a store.
- `data_wdata_i` input 32: store data.
- `data_gnt_o` output 1: load/store accepted this cycle (combinational).
- `data_rvalid_o` output 1: load/store response valid.
- `data_rdata_o` output 32: load data; 0 for stores.
- `data_err_o` output 1: error response, qualified by `data_rvalid_o`.
- `instr_cnt_o` output 32: completed fetch responses.
- `data_cnt_o` output 32: completed load/store responses, errors included.

## Operation
- Offset = addr − BASE_ADDR (32-bit, wraps). The access is in range when offset < 4·2^MEM_WORDS_LOG2. Word index = offset[MEM_WORDS_LOG2+1:2].
- **Arbitration.** At most one grant per cycle.
  - Data has priority.
  - Exception: if `instr_req_i` was high and not granted in the previous cycle, instruction wins this cycle. This bounds instruction starvation to 1 cycle.
  - A lone requester is granted whenever it is not stalled (see Configuration).
- A requester must hold req, addr, we, be and wdata stable until it is granted. The block never ignores a held request for more than 1 cycle, stalls excepted.
- **Store.** The byte lanes selected by `data_be_i` are written at the grant edge. `be`=0 writes nothing but still responds.
- **Load/fetch.** The word is read at the grant edge and returned in the next cycle.
- **Out-of-range data access.** No write. Response has `data_err_o`=1 and `data_rdata_o`=0.
- **Out-of-range fetch.** Response with `instr_rdata_o`=32'h0000_0000, which the core decodes as an illegal instruction.
- **Counters.** Increment on each rvalid and wrap at 2^32.
- Array contents are not reset. The testbench preloads them through a backdoor.

## Timing
- Grant at edge N gives rvalid high for exactly cycle N+1, with rdata and err valid in that cycle.
- Back-to-back grants on consecutive cycles are legal. Each port can have one response per cycle and rvalid may stay high continuously.
- Read-after-write is coherent: a load granted the cycle after a store to the same word returns the merged new value.
- **Simultaneous requests:**
  - Data wins the cycle.
  - Instruction wins the following cycle.
  - If the data request is then still pending, it is granted the cycle after that.
- **Reset values:** `instr_gnt_o`=`data_gnt_o`=0 (both forced low while `rst_i` is high), `*_rvalid_o`=0, `*_rdata_o`=0, `data_err_o`=0, counters=0.
- **Reset asserted mid-transaction:** pending responses are dropped immediately and asynchronously, and the counters do not increment. A store whose grant edge already occurred stays committed.

## Configuration
- Macro `CORE_MEM_RESP_STALL_EN`.
- **Defined:**
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded to 16'hACE1 on reset and advances every cycle.
  - In a cycle where LFSR bit 0 = 1, both grants are forced to 0.
  - The starvation flag still updates, so instruction priority survives the stall.
- **Undefined:** no LFSR, no stalls; grants follow arbitration only.

## Structure
- Package `core_mem_pkg` holds:
  - the request typedef (addr, we, be, wdata);
  - the LFSR seed and tap constants;
  - the out-of-range fetch word constant `MEM_OOR_INSTR` = 32'h0.
- Sub-module `core_mem_lfsr`: free-running LFSR with async active-high reset. It is instantiated only under `CORE_MEM_RESP_STALL_EN`.

## Test plan
- **Preload and fetch:** preload word 0 = 32'h0000_0093. Fetch at 0 → gnt the same cycle; next cycle `instr_rvalid_o`=1 and `instr_rdata_o`=32'h0000_0093; `instr_cnt_o`=1.
- **Partial store then load:** store 32'hDEADBEEF, be=4'b0101, to 0x40 over a preload of 0. Load 0x40 the next cycle → `data_rdata_o`=32'h00AD00EF.
- **Simultaneous requests:** instr and data both request for 4 cycles → grant pattern D, I, D, I.
- **Out of range:** data load at 0x0001_0000 with default parameters → rvalid with `data_err_o`=1 and `data_rdata_o`=0, no array change. Fetch at the same address → rdata 0.
- **Reset mid-transaction:** assert `rst_i` in the cycle after a grant → rvalid deasserts immediately and counters read 0.
- **Stall build:** with `CORE_MEM_RESP_STALL_EN`, run 1000 single-cycle load requests → every request is answered, no grant in any LFSR bit-0 cycle, `data_cnt_o`=1000.
